// File: rtl/conv_1st_pkg.sv
// Shared constants and drain FSM encoding for the first-layer convolution drain path.
package conv_1st_pkg;

  localparam int LANES = 40;
  localparam int DW    = 8;
  localparam int LW    = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/conv_1st_bank.sv
// One LANES x DW result bank: whole-vector write on we, combinational lane read.
// Contents are deliberately not reset; the full flags in the drain decide validity.
module conv_1st_bank
  import conv_1st_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [LANES*DW-1:0] din,
  input  logic [LW-1:0]       sel,
  output logic [DW-1:0]       dout
);

  logic [DW-1:0] mem [LANES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) begin
        mem[k] <= din[k*DW +: DW];
      end
    end
  end

  // Indices past the last lane never occur in use; return zero rather than X.
  always_comb begin
    dout = '0;
    if (sel < LW'(LANES)) dout = mem[sel];
  end

endmodule

// File: rtl/conv_1st_drain.sv
// Ping-pong capture of conv result vectors, drained one lane/cycle on valid/ready; lane 0 the cycle after valid_i.
// Upstream cannot stall: one spare bank absorbs slack, a vector arriving with both banks held is dropped and flagged.
module conv_1st_drain
  import conv_1st_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] conv_i,
  input  logic                valid_i,
  input  logic                clr_ovf_i,
  output logic [DW-1:0]       data_o,
  output logic [LW-1:0]       lane_o,
  output logic                last_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  drain_state_t  state, state_nxt;
  logic [1:0]    full, full_nxt;
  logic [1:0]    bank_we, release_b;
  logic          wr_sel, rd_sel;
  logic [LW-1:0] lane_cnt;
  logic          overflow;
  logic          xfer, last_xfer, accept, drop;
  logic [DW-1:0] rd_dat [2];

  assign xfer      = (state == STREAM) && ready_i;
  assign last_xfer = xfer && (lane_cnt == LAST_LANE);

  always_comb begin
    release_b = '0;
    if (last_xfer) release_b[rd_sel] = 1'b1;
  end

  // A bank being released by this cycle's last beat may be refilled at the same edge.
  assign accept = valid_i && (!full[wr_sel] || release_b[wr_sel]);
  assign drop   = valid_i && !accept;

  always_comb begin
    bank_we = '0;
    if (accept) bank_we[wr_sel] = 1'b1;
  end

  assign full_nxt = (full & ~release_b) | bank_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Looking at full_nxt lets a fresh capture start streaming the very next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full_nxt[rd_sel]) state_nxt = STREAM;
      STREAM:  if (last_xfer && !full_nxt[~rd_sel]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      lane_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) wr_sel <= ~wr_sel;
      if (last_xfer) begin
        rd_sel   <= ~rd_sel;
        lane_cnt <= '0;
      end else if (xfer) begin
        lane_cnt <= lane_cnt + 1'b1;
      end
      if (clr_ovf_i)  overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : gen_bank
    conv_1st_bank u_bank (
      .clk  (clk),
      .we   (bank_we[b]),
      .din  (conv_i),
      .sel  (lane_cnt),
      .dout (rd_dat[b])
    );
  end

  assign valid_o    = (state == STREAM);
  assign data_o     = valid_o ? rd_dat[rd_sel] : '0;
  assign lane_o     = lane_cnt;
  assign last_o     = valid_o && (lane_cnt == LAST_LANE);
  assign overflow_o = overflow;
  assign busy_o     = |full;

endmodule

// File: tb/tb_conv_1st_drain.sv
// Randomised scoreboard bench for conv_1st_drain against a byte-queue reference model.
module tb_conv_1st_drain;
  import conv_1st_pkg::*;

  typedef logic [LANES*DW-1:0] vec_t;
  typedef struct {
    logic [DW-1:0] dat;
    int            lane;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  vec_t          conv_i;
  logic          valid_i, clr_ovf_i, ready_i;
  logic [DW-1:0] data_o;
  logic [LW-1:0] lane_o;
  logic          last_o, valid_o, overflow_o, busy_o;

  conv_1st_drain dut (
    .clk        (clk),
    .rst        (rst),
    .conv_i     (conv_i),
    .valid_i    (valid_i),
    .clr_ovf_i  (clr_ovf_i),
    .data_o     (data_o),
    .lane_o     (lane_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];
  int    mdl_bytes = 0;   // bytes accepted but not yet transferred
  logic  exp_ovf   = 1'b0;
  logic  exp_vld_c = 1'b0;
  logic  exp_ovf_c = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t fill(input logic [DW-1:0] b);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = b;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  // One clock of stimulus; the model derives acceptance from how many whole or
  // partial vectors are still queued and whether the head's final byte leaves now.
  task automatic cycle(input logic v, input vec_t vec, input logic rdy, input logic clr);
    int   held;
    logic xfer, rel, acc;
    @(posedge clk);
    #1;
    valid_i   = v;
    conv_i    = vec;
    ready_i   = rdy;
    clr_ovf_i = clr;
    held      = (mdl_bytes + LANES - 1) / LANES;
    xfer      = (mdl_bytes > 0) && rdy;
    rel       = xfer && (mdl_bytes % LANES == 1);
    exp_vld_c = (mdl_bytes > 0);
    exp_ovf_c = exp_ovf;
    acc       = 1'b0;
    if (v) begin
      acc = (held < 2) || rel;
      if (acc) begin
        for (int k = 0; k < LANES; k++) begin
          beat_t bt;
          bt.dat  = vec[k*DW +: DW];
          bt.lane = k;
          bt.last = (k == LANES - 1);
          sb.push_back(bt);
        end
      end
    end
    if (clr)           exp_ovf = 1'b0;
    else if (v && !acc) exp_ovf = 1'b1;
    mdl_bytes = mdl_bytes - (xfer ? 1 : 0) + (acc ? LANES : 0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic pulse_reset(input logic check_stream);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clr_ovf_i = 1'b0;
    if (check_stream) begin
      chk("pre_rst_valid", valid_o, 1);
      chk("pre_rst_lane", lane_o, 17);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_last", last_o, 0);
    sb.delete();
    mdl_bytes = 0;
    exp_ovf   = 1'b0;
    exp_vld_c = 1'b0;
    exp_ovf_c = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_dat;
  logic [LW-1:0] prev_lane;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      chk("valid_o", valid_o, exp_vld_c);
      chk("busy_o", busy_o, exp_vld_c);
      chk("overflow_o", overflow_o, exp_ovf_c);
      if (stall_prev) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, prev_dat);
        chk("hold_lane", lane_o, prev_lane);
        chk("hold_last", last_o, prev_last);
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t bt;
          bt = sb.pop_front();
          chk("data_o", data_o, bt.dat);
          chk("lane_o", lane_o, bt.lane);
          chk("last_o", last_o, bt.last);
        end
      end else if (!valid_o) begin
        chk("idle_data", data_o, 0);
        chk("idle_last", last_o, 0);
      end
      stall_prev = valid_o && !ready_i;
      prev_dat   = data_o;
      prev_lane  = lane_o;
      prev_last  = last_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d beats outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   guard;
    rst = 1'b1;
    valid_i = 1'b0;
    clr_ovf_i = 1'b0;
    ready_i = 1'b0;
    conv_i = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_valid", valid_o, 0);
    chk("reset_last", last_o, 0);
    chk("reset_lane", lane_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_ovf", overflow_o, 0);

    // single vector, lane k = k+1
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(k + 1);
    cycle(1'b1, v, 1'b1, 1'b0);
    idle(45, 1'b1);

    // two vectors three cycles apart stream without a gap
    cycle(1'b1, fill(8'h11), 1'b1, 1'b0);
    idle(2, 1'b1);
    cycle(1'b1, fill(8'h22), 1'b1, 1'b0);
    idle(85, 1'b1);

    // ready toggling every cycle
    cycle(1'b1, rand_vec(), 1'b1, 1'b0);
    for (int i = 0; i < 90; i++) cycle(1'b0, '0, 1'(i % 2), 1'b0);
    idle(10, 1'b1);

    // three strobes under stall: third dropped, then clear overflow
    cycle(1'b1, rand_vec(), 1'b0, 1'b0);
    cycle(1'b1, rand_vec(), 1'b0, 1'b0);
    cycle(1'b1, rand_vec(), 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(85, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // both banks full, new vector on the last beat of the first
    cycle(1'b1, fill(8'hA5), 1'b0, 1'b0);
    cycle(1'b1, fill(8'h5A), 1'b0, 1'b0);
    idle(3, 1'b0);
    guard = 0;
    while (mdl_bytes != LANES + 1 && guard < 100) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    chk("coincide_reach", guard < 100, 1);
    cycle(1'b1, fill(8'hC3), 1'b1, 1'b0);
    idle(90, 1'b1);
    chk("coincide_ovf", overflow_o, 0);

    // reset while lane 17 is on the bus
    cycle(1'b1, rand_vec(), 1'b1, 1'b0);
    idle(17, 1'b1);
    pulse_reset(1'b1);
    cycle(1'b1, rand_vec(), 1'b1, 1'b0);
    idle(45, 1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 24) == 0), rand_vec(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end

    guard = 0;
    while ((mdl_bytes != 0 || sb.size() != 0) && guard < 200) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    idle(2, 1'b1);
    chk("final_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
